// File: rtl/unsigned_mac_pkg.sv
// Shared definitions for the unsigned 8x8 multiply-accumulate block.
// Holds the controller state encoding and the default accumulator and
// term-counter widths used by unsigned_mac_8.
package unsigned_mac_pkg;

  localparam int ACC_W_DEF = 24;
  localparam int CNT_W_DEF = 16;

  // RUN: accepting terms. DRAIN: last term seen, waiting for the pipeline
  // to empty into the accumulator. HOLD: result presented, waiting for out_ready.
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/wallace_unsigned_multiplier_CLA_Reduced_8.sv
// Combinational 8x8 unsigned multiplier: carry-save (Wallace) reduction of
// the eight partial-product rows down to two, then a carry-lookahead adder.
// Ports: a, b - 8-bit unsigned operands; p - 16-bit product a*b.
module wallace_unsigned_multiplier_CLA_Reduced_8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  // 3:2 compressor on whole rows. The carry row is shifted up one column;
  // anything pushed past bit 15 is dropped, which is safe because the true
  // product never exceeds 16 bits.
  function automatic logic [15:0] csa_s(input logic [15:0] x, y, z);
    return x ^ y ^ z;
  endfunction

  function automatic logic [15:0] csa_c(input logic [15:0] x, y, z);
    return ((x & y) | (x & z) | (y & z)) << 1;
  endfunction

  logic [15:0] pp [8];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      pp[i] = b[i] ? ({8'b0, a} << i) : 16'b0;
    end
  end

  // Reduction tree: 8 -> 6 -> 4 -> 3 -> 2 rows.
  logic [15:0] s0, c0, s1, c1, s2, c2, s3, c3, s4, c4, s5, c5;

  assign s0 = csa_s(pp[0], pp[1], pp[2]);
  assign c0 = csa_c(pp[0], pp[1], pp[2]);
  assign s1 = csa_s(pp[3], pp[4], pp[5]);
  assign c1 = csa_c(pp[3], pp[4], pp[5]);

  assign s2 = csa_s(s0, c0, s1);
  assign c2 = csa_c(s0, c0, s1);
  assign s3 = csa_s(c1, pp[6], pp[7]);
  assign c3 = csa_c(c1, pp[6], pp[7]);

  assign s4 = csa_s(s2, c2, s3);
  assign c4 = csa_c(s2, c2, s3);

  assign s5 = csa_s(s4, c4, c3);
  assign c5 = csa_c(s4, c4, c3);

  // Final adder: 4-bit groups; group carry-outs come from group
  // generate/propagate so the inter-group path does not ripple bit by bit.
  logic [15:0] g, pr, cy;

  assign g  = s5 & c5;
  assign pr = s5 ^ c5;

  always_comb begin
    cy = 16'b0;
    for (int grp = 0; grp < 4; grp++) begin
      for (int k = 0; k < 3; k++) begin
        cy[grp*4 + k + 1] = g[grp*4 + k] | (pr[grp*4 + k] & cy[grp*4 + k]);
      end
      if (grp < 3) begin
        cy[grp*4 + 4] = g[grp*4 + 3]
                      | (pr[grp*4 + 3] & g[grp*4 + 2])
                      | (pr[grp*4 + 3] & pr[grp*4 + 2] & g[grp*4 + 1])
                      | (pr[grp*4 + 3] & pr[grp*4 + 2] & pr[grp*4 + 1] & g[grp*4])
                      | (pr[grp*4 + 3] & pr[grp*4 + 2] & pr[grp*4 + 1] & pr[grp*4]
                         & cy[grp*4]);
      end
    end
  end

  assign p = pr ^ cy;

endmodule

// File: rtl/unsigned_mac_8.sv
// Grouped unsigned 8x8 multiply-accumulate with valid/ready on both sides.
// Ports: clk/rst_n; in_valid/in_ready/in_a/in_b/in_last operand stream;
// out_valid/out_ready/out_acc/out_count/out_ovf group result.
module unsigned_mac_8
  import unsigned_mac_pkg::*;
#(
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t state;

  logic             accept;
  logic             s1_vld, s1_last;
  logic [7:0]       s1_a, s1_b;
  logic             s2_vld, s2_last;
  logic [15:0]      s2_prod;
  logic [15:0]      prod;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic             ovf;
  logic [ACC_W:0]   acc_sum;

  // Only RUN takes new terms; once the last term is in, the group is
  // closed until its result has been handed off.
  assign in_ready = (state == RUN);
  assign accept   = in_valid && in_ready;

  wallace_unsigned_multiplier_CLA_Reduced_8 u_mul (
    .a (s1_a),
    .b (s1_b),
    .p (prod)
  );

  // Extra top bit captures the carry-out for the sticky overflow flag.
  assign acc_sum = {1'b0, acc} + {{(ACC_W + 1 - 16){1'b0}}, s2_prod};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
      s1_a    <= 8'd0;
      s1_b    <= 8'd0;
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
      s2_prod <= 16'd0;
    end else begin
      s1_vld <= accept;
      if (accept) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_last <= in_last;
      end
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_prod <= prod;
        s2_last <= s1_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s2_vld) begin
        acc   <= acc_sum[ACC_W-1:0];
        count <= count + CNT_ONE;
        ovf   <= ovf | acc_sum[ACC_W];
      end
      case (state)
        RUN: begin
          if (accept && in_last) state <= DRAIN;
        end
        DRAIN: begin
          // Terms behind the last one cannot exist, so the last-marked
          // term reaching the accumulator means the group is complete.
          if (s2_vld && s2_last) begin
            state     <= HOLD;
            out_valid <= 1'b1;
          end
        end
        HOLD: begin
          // Pipeline is empty here, so clearing cannot race an accumulate.
          if (out_ready) begin
            state     <= RUN;
            out_valid <= 1'b0;
            acc       <= '0;
            count     <= '0;
            ovf       <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign out_acc   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_unsigned_mac_8.sv
module tb_unsigned_mac_8;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        in_last;
  logic        out_ready;

  // Default-width instance
  logic        in_ready;
  logic        out_valid;
  logic [23:0] out_acc;
  logic [15:0] out_count;
  logic        out_ovf;

  // ACC_W=16 instance, driven by the same stimulus
  logic        in_ready_16;
  logic        out_valid_16;
  logic [15:0] out_acc_16;
  logic [15:0] out_count_16;
  logic        out_ovf_16;

  int tests;
  int fails;

  unsigned_mac_8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_acc   (out_acc),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  unsigned_mac_8 #(.ACC_W(16), .CNT_W(16)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready_16),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid_16),
    .out_ready (out_ready),
    .out_acc   (out_acc_16),
    .out_count (out_count_16),
    .out_ovf   (out_ovf_16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one term and hold it until an edge where in_ready was high.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic l);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = l;
    for (int i = 0; i < 50 && !ok; i++) begin
      ok = in_ready;
      tick();
    end
    check("send_accepted", ok, 1'b1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_a     = 8'd0;
    in_b     = 8'd0;
    in_last  = 1'b0;
  endtask

  task automatic wait_out();
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    check("out_valid_timeout", out_valid, 1'b1);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    out_ready = 1'b0;
    idle();

    // ---- reset state ----
    tick();
    tick();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_acc", out_acc, 24'd0);
    check("rst_count", out_count, 16'd0);
    check("rst_ovf", out_ovf, 1'b0);
    rst_n = 1'b1;
    tick();
    check("post_rst_in_ready", in_ready, 1'b1);

    // ---- single term latency: 255*255 = 65025 ----
    send(8'd255, 8'd255, 1'b1);   // accepted at E0, now E0+1ns
    idle();
    check("single_e0_valid", out_valid, 1'b0);
    check("single_e0_ready", in_ready, 1'b0);
    tick();
    check("single_e1_valid", out_valid, 1'b0);
    tick();
    check("single_e2_valid", out_valid, 1'b1);
    check("single_acc", out_acc, 24'd65025);
    check("single_count", out_count, 16'd1);
    check("single_ovf", out_ovf, 1'b0);
    out_ready = 1'b1;
    tick();
    check("single_consumed_valid", out_valid, 1'b0);
    check("single_consumed_ready", in_ready, 1'b1);
    check("single_cleared_acc", out_acc, 24'd0);

    // ---- back-to-back group, out_ready held high throughout ----
    // 12 + 30 + 65025 = 65067
    send(8'd3, 8'd4, 1'b0);
    send(8'd5, 8'd6, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    idle();
    check("b2b_e0_valid", out_valid, 1'b0);
    tick();
    check("b2b_e1_valid", out_valid, 1'b0);
    tick();
    check("b2b_e2_valid", out_valid, 1'b1);
    check("b2b_acc", out_acc, 24'd65067);
    check("b2b_count", out_count, 16'd3);
    check("b2b_ovf", out_ovf, 1'b0);
    check("b2b_acc16", out_acc_16, 16'd65067);
    check("b2b_ovf16", out_ovf_16, 1'b0);
    tick();
    check("b2b_consumed", out_valid, 1'b0);
    out_ready = 1'b0;

    // ---- overflow on 16-bit accumulator: 2*65025 = 130050 ----
    send(8'd255, 8'd255, 1'b0);
    send(8'd255, 8'd255, 1'b1);
    idle();
    wait_out();
    check("ovf_acc16", out_acc_16, 16'd64514);
    check("ovf_flag16", out_ovf_16, 1'b1);
    check("ovf_count16", out_count_16, 16'd2);
    check("ovf_acc24", out_acc, 24'd130050);
    check("ovf_flag24", out_ovf, 1'b0);

    // ---- HOLD stalls for 5 cycles, in_valid must be ignored ----
    in_valid = 1'b1;
    in_a     = 8'd7;
    in_b     = 8'd9;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_acc", out_acc, 24'd130050);
      check("hold_count", out_count, 16'd2);
    end
    idle();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hold_release_valid", out_valid, 1'b0);
    check("hold_release_acc16", out_acc_16, 16'd0);
    check("hold_release_ovf16", out_ovf_16, 1'b0);

    // ---- next group starts from zero, ovf cleared ----
    send(8'd1, 8'd1, 1'b1);
    idle();
    wait_out();
    check("next_acc16", out_acc_16, 16'd1);
    check("next_ovf16", out_ovf_16, 1'b0);
    check("next_acc24", out_acc, 24'd1);
    check("next_count", out_count, 16'd1);

    // ---- out_ready and in_valid in the same HOLD cycle ----
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = 8'd2;
    in_b      = 8'd3;
    in_last   = 1'b1;
    tick();                       // edge H: consume, no accept
    out_ready = 1'b0;
    check("sim_consumed", out_valid, 1'b0);
    check("sim_ready_after", in_ready, 1'b1);
    tick();                       // edge H+1: accept
    idle();
    check("sim_accepted", in_ready, 1'b0);
    tick();                       // H+2: would be valid if accepted at H
    check("sim_not_early", out_valid, 1'b0);
    tick();                       // H+3
    check("sim_valid", out_valid, 1'b1);
    check("sim_acc", out_acc, 24'd6);
    check("sim_count", out_count, 16'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // ---- reset with terms in flight ----
    send(8'd10, 8'd10, 1'b0);
    send(8'd10, 8'd10, 1'b0);
    rst_n = 1'b0;
    #2;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_acc", out_acc, 24'd0);
    check("midrst_count", out_count, 16'd0);
    tick();
    tick();
    tick();
    rst_n = 1'b1;
    check("midrst_acc_held", out_acc, 24'd0);
    send(8'd1, 8'd1, 1'b1);
    idle();
    wait_out();
    check("midrst_final_acc", out_acc, 24'd1);
    check("midrst_final_count", out_count, 16'd1);
    check("midrst_final_ovf", out_ovf, 1'b0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
